// File: rtl/spike_event_encoder.sv
// Address-event encoder: snapshots a spike vector on each timestep strobe and streams one
// {address, timestep} event per set bit, lowest address first, over a valid/ready handshake.
module spike_event_encoder #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned TS_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 step_i,
  input  logic [N_NEURONS-1:0] spikes_i,
  output logic                 ev_valid_o,
  input  logic                 ev_ready_i,
  output logic [ADDR_W-1:0]    ev_addr_o,
  output logic [TS_W-1:0]      ev_ts_o,
  output logic                 ev_last_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0]      ev_ts_q, ev_ts_d;
  logic                 overrun_q, overrun_d;

  logic [N_NEURONS-1:0] pending_rest;
  logic [ADDR_W-1:0]    low_idx;
  logic                 one_left;
  logic                 valid;
  logic                 hs;
  logic                 snap_nz;

  // pending & (pending - 1) drops the lowest set bit; zero result means at most one bit was set
  assign pending_rest = pending_q & (pending_q - {{(N_NEURONS-1){1'b0}}, 1'b1});
  assign one_left     = (pending_q != '0) && (pending_rest == '0);

  always_comb begin
    low_idx = '0;
    for (int i = int'(N_NEURONS) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = ADDR_W'(i);
    end
  end

  assign valid   = (state_q == StSend);
  assign hs      = valid & ev_ready_i;
  assign snap_nz = step_i & (|spikes_i);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ev_ts_d   = ev_ts_q;
    overrun_d = overrun_q;
    ts_cnt_d  = step_i ? ts_cnt_q + TS_W'(1) : ts_cnt_q;
    case (state_q)
      StIdle: begin
        if (snap_nz) begin
          pending_d = spikes_i;
          ev_ts_d   = ts_cnt_q;
          state_d   = StSend;
        end
      end
      default: begin
        if (hs && one_left) begin
          // Final handshake: a coincident non-empty snapshot chains on with no bubble
          if (snap_nz) begin
            pending_d = spikes_i;
            ev_ts_d   = ts_cnt_q;
          end else begin
            pending_d = '0;
            state_d   = StIdle;
          end
        end else begin
          if (hs) pending_d = pending_rest;
          if (snap_nz) overrun_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pending_q <= '0;
      ts_cnt_q  <= '0;
      ev_ts_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ts_cnt_q  <= ts_cnt_d;
      ev_ts_q   <= ev_ts_d;
      overrun_q <= overrun_d;
    end
  end

  assign ev_valid_o = valid;
  assign busy_o     = valid;
  assign ev_addr_o  = valid ? low_idx : '0;
  assign ev_last_o  = valid & one_left;
  assign ev_ts_o    = ev_ts_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: a vector table for ordering, backpressure and chaining,
// plus hand-written sequences for overrun, async reset and timestep wrap.
module tb_spike_event_encoder;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       step_i;
  logic [7:0] spikes_i;
  logic       ev_ready_i;
  logic       ev_valid_o;
  logic [2:0] ev_addr_o;
  logic [7:0] ev_ts_o;
  logic       ev_last_o;
  logic       busy_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;

  spike_event_encoder #(
    .N_NEURONS(8),
    .ADDR_W   (3),
    .TS_W     (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .step_i    (step_i),
    .spikes_i  (spikes_i),
    .ev_valid_o(ev_valid_o),
    .ev_ready_i(ev_ready_i),
    .ev_addr_o (ev_addr_o),
    .ev_ts_o   (ev_ts_o),
    .ev_last_o (ev_last_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       step;
    logic [7:0] spk;
    logic       rdy;
    logic       v;
    logic [2:0] a;
    logic [7:0] ts;
    logic       l;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] spk, input logic r);
    step_i     = s;
    spikes_i   = spk;
    ev_ready_i = r;
  endtask

  int valid_cnt;
  logic [2:0] seen_addr;
  logic [7:0] seen_ts;
  logic seen_last;

  initial begin
    // Each row: inputs for this cycle, outputs expected during this cycle (before the edge)
    // Ordering: 0xA4 at ts 0 -> addr 2,5,7
    vecs[0]  = '{1'b1, 8'hA4, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 3'd2, 8'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'd0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0};
    // Backpressure: 0x81 at ts 1, ready 0,1,0,0,1
    vecs[5]  = '{1'b1, 8'h81, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'd1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'd1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'd1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'd1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd1, 1'b0};
    // Back-to-back: 0x09 at ts 2, then 0x02 at ts 3 on the final handshake
    vecs[12] = '{1'b1, 8'h09, 1'b1, 1'b0, 3'd0, 8'd1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'd2, 1'b0};
    vecs[14] = '{1'b1, 8'h02, 1'b1, 1'b1, 3'd3, 8'd2, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'd3, 1'b1};
    // 0x01 at ts 4, then an empty step on its final handshake returns to idle
    vecs[16] = '{1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 8'd3, 1'b0};
    vecs[17] = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'd4, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd4, 1'b0};

    // Reset with no clock edge yet
    rst_ni = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #3;
    check("rst_valid", 32'(ev_valid_o), 32'd0);
    check("rst_addr", 32'(ev_addr_o), 32'd0);
    check("rst_ts", 32'(ev_ts_o), 32'd0);
    check("rst_last", 32'(ev_last_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    #9 rst_ni = 1'b1;
    drive(1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid%0d", i), 32'(ev_valid_o), 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].step, vecs[i].spk, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), 32'(ev_valid_o), 32'(vecs[i].v));
      check($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].v));
      check($sformatf("v%0d_addr", i), 32'(ev_addr_o), 32'(vecs[i].a));
      check($sformatf("v%0d_ts", i), 32'(ev_ts_o), 32'(vecs[i].ts));
      check($sformatf("v%0d_last", i), 32'(ev_last_o), 32'(vecs[i].l));
      check($sformatf("v%0d_overrun", i), 32'(overrun_o), 32'd0);
      tick();
    end

    // Overrun: ts_cnt is 6 here
    drive(1'b1, 8'hFF, 1'b0);
    tick();
    drive(1'b1, 8'h00, 1'b0);
    tick();
    check("ovr_empty_step", 32'(overrun_o), 32'd0);
    drive(1'b1, 8'h01, 1'b0);
    tick();
    check("ovr_set", 32'(overrun_o), 32'd1);
    check("ovr_hold_addr", 32'(ev_addr_o), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovr_ev%0d_valid", i), 32'(ev_valid_o), 32'd1);
      check($sformatf("ovr_ev%0d_addr", i), 32'(ev_addr_o), 32'(i));
      check($sformatf("ovr_ev%0d_ts", i), 32'(ev_ts_o), 32'd6);
      check($sformatf("ovr_ev%0d_last", i), 32'(ev_last_o), 32'(i == 7));
      tick();
    end
    check("ovr_drained", 32'(ev_valid_o), 32'd0);
    check("ovr_sticky", 32'(overrun_o), 32'd1);
    // Dropped steps still advanced the counter: next snapshot is ts 9
    drive(1'b1, 8'h01, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check("ovr_next_ts", 32'(ev_ts_o), 32'd9);
    check("ovr_next_valid", 32'(ev_valid_o), 32'd1);

    // Async reset mid-cycle while an event is stalled
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ev_valid_o), 32'd0);
    check("mid_rst_ts", 32'(ev_ts_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_overrun", 32'(overrun_o), 32'd0);
    #3 rst_ni = 1'b1;
    ev_ready_i = 1'b1;
    tick();
    check("mid_rst_discard", 32'(ev_valid_o), 32'd0);

    // Sparsity and timestep wrap: only step 257 carries a spike
    valid_cnt = 0;
    seen_addr = '0;
    seen_ts   = '0;
    seen_last = 1'b0;
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, (k == 257) ? 8'h10 : 8'h00, 1'b1);
      tick();
      if (ev_valid_o) begin
        valid_cnt++;
        seen_addr = ev_addr_o;
        seen_ts   = ev_ts_o;
        seen_last = ev_last_o;
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    if (ev_valid_o) valid_cnt++;
    check("wrap_count", 32'(valid_cnt), 32'd1);
    check("wrap_addr", 32'(seen_addr), 32'd4);
    check("wrap_ts", 32'(seen_ts), 32'd1);
    check("wrap_last", 32'(seen_last), 32'd1);
    check("wrap_overrun", 32'(overrun_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
